video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/sync_delay_line.sv | 27 ++
 rtl/video_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Default arcade raster timing, vertical state encoding and the RGB332 pixel layout.
// Shared by the timing generator and its sync delay line.
package video_timing_pkg;

    localparam int H_TOTAL_DEF      = 384;
    localparam int H_ACTIVE_DEF     = 256;
    localparam int H_SYNC_START_DEF = 288;
    localparam int H_SYNC_LEN_DEF   = 32;
    localparam int V_TOTAL_DEF      = 264;
    localparam int V_ACTIVE_DEF     = 232;
    localparam int V_SYNC_START_DEF = 244;
    localparam int V_SYNC_LEN_DEF   = 4;
    localparam int LAT_DEF          = 2;

    typedef enum logic [1:0] {
        V_ACT,
        V_FRONT,
        V_SYNC,
        V_BACK
    } vstate_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

endpackage

// File: rtl/sync_delay_line.sv
// Shift register carrying {hsync, vsync, blank, frame_start}; latency DEPTH clocks.
// No backpressure: shifts every clock, flushes to idle raster levels on reset.
module sync_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic       clk6m,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    localparam logic [3:0] IDLE = 4'b1110;

    logic [3:0] stage [DEPTH];

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster source: h/v counters + vertical FSM, one pix_req per active clock, aligned sync/blank/rgb out.
// Latency: outputs trail pix_req by LAT+1 clocks. No backpressure: a missing pixel blacks out and sets underflow_o.
// COLOR_BARS_EN: outputs an x ramp in the active area instead of fetched pixels; pix_req stays low.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
    parameter int LAT          = LAT_DEF
) (
    input  logic       clk6m,
    input  logic       reset_n,
    output logic       pix_req,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    input  logic       clr_underflow,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_o,
    output logic [7:0] rgb_o,
    output logic       frame_start_o,
    output logic       underflow_o
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] HS_BEG = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACTN = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG = 9'(V_SYNC_START);
    localparam logic [8:0] VS_END = 9'(V_SYNC_START + V_SYNC_LEN);

    logic [8:0] hcnt, vcnt, vcnt_nxt;
    logic       h_wrap;
    vstate_t    vstate, vstate_nxt;

    assign h_wrap   = (hcnt == H_LAST);
    assign vcnt_nxt = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            hcnt   <= '0;
            vcnt   <= '0;
            vstate <= V_ACT;
        end else begin
            hcnt   <= h_wrap ? 9'd0 : hcnt + 9'd1;
            vstate <= vstate_nxt;
            if (h_wrap) vcnt <= vcnt_nxt;
        end
    end

    // Vertical state only moves on line boundaries, keyed on the line being entered.
    always_comb begin
        vstate_nxt = vstate;
        if (h_wrap) begin
            case (vstate)
                V_ACT:   if (vcnt_nxt == V_ACTN) vstate_nxt = V_FRONT;
                V_FRONT: if (vcnt_nxt == VS_BEG) vstate_nxt = V_SYNC;
                V_SYNC:  if (vcnt_nxt == VS_END) vstate_nxt = V_BACK;
                V_BACK:  if (vcnt_nxt == 9'd0)   vstate_nxt = V_ACT;
                default: vstate_nxt = V_ACT;
            endcase
        end
    end

    logic       act_s0, hs_s0, vs_s0, fs_s0;
    logic [8:0] x_s0, y_s0;

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            act_s0 <= 1'b0;
            hs_s0  <= 1'b1;
            vs_s0  <= 1'b1;
            fs_s0  <= 1'b0;
            x_s0   <= '0;
            y_s0   <= '0;
        end else begin
            act_s0 <= (hcnt < H_ACT) && (vstate == V_ACT);
            hs_s0  <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
            vs_s0  <= (vstate != V_SYNC);
            fs_s0  <= (hcnt == 9'd0) && (vcnt == 9'd0);
            x_s0   <= hcnt;
            y_s0   <= vcnt;
        end
    end

    assign pix_x = x_s0;
    assign pix_y = y_s0;

    logic [3:0] sync_q;

    sync_delay_line #(.DEPTH(LAT + 1)) u_sync_dly (
        .clk6m   (clk6m),
        .reset_n (reset_n),
        .d       ({hs_s0, vs_s0, ~act_s0, fs_s0}),
        .q       (sync_q)
    );

    assign {hsync_o, vsync_o, blank_o, frame_start_o} = sync_q;

    // act_pipe[LAT-1] marks the clock in which the response to a request is due.
    logic [LAT-1:0] act_pipe;

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            act_pipe <= '0;
        end else begin
            act_pipe[0] <= act_s0;
            for (int i = 1; i < LAT; i++) act_pipe[i] <= act_pipe[i-1];
        end
    end

`ifdef COLOR_BARS_EN
    logic [7:0] bar_pipe [LAT];
    logic       unused_fetch;

    assign pix_req      = 1'b0;
    assign unused_fetch = ^{pix_data, pix_valid, clr_underflow, y_s0, x_s0[8]};

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) bar_pipe[i] <= '0;
            rgb_o       <= '0;
            underflow_o <= 1'b0;
        end else begin
            bar_pipe[0] <= x_s0[7:0];
            for (int i = 1; i < LAT; i++) bar_pipe[i] <= bar_pipe[i-1];
            rgb_o       <= act_pipe[LAT-1] ? bar_pipe[LAT-1] : 8'd0;
            underflow_o <= 1'b0;
        end
    end
`else
    rgb332_t pix_in;
    logic    miss;

    assign pix_req = act_s0;
    assign pix_in  = pix_data;
    assign miss    = act_pipe[LAT-1] & ~pix_valid;

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            rgb_o       <= '0;
            underflow_o <= 1'b0;
        end else begin
            rgb_o       <= (act_pipe[LAT-1] && pix_valid) ? pix_in : 8'd0;
            underflow_o <= miss | (underflow_o & ~clr_underflow);
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: a raster reference model feeds a scoreboard queue,
// a pixel-source model answers pix_req, and a monitor pops and compares every clock.
module tb_video_timing_gen;

    localparam int HT  = 300;
    localparam int HA  = 256;
    localparam int HSS = 270;
    localparam int HSL = 16;
    localparam int VT  = 24;
    localparam int VA  = 16;
    localparam int VSS = 19;
    localparam int VSL = 2;
    localparam int LAT = 2;
    localparam int FRAME = HT * VT;
`ifdef COLOR_BARS_EN
    localparam bit BARS = 1'b1;
`else
    localparam bit BARS = 1'b0;
`endif

    logic       clk6m = 1'b0;
    logic       reset_n;
    logic       pix_req;
    logic [8:0] pix_x, pix_y;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       clr_underflow;
    logic       hsync_o, vsync_o, blank_o, frame_start_o, underflow_o;
    logic [7:0] rgb_o;

    always #5 clk6m = ~clk6m;

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .LAT(LAT)
    ) dut (
        .clk6m(clk6m), .reset_n(reset_n),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .pix_valid(pix_valid), .clr_underflow(clr_underflow),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o), .rgb_o(rgb_o),
        .frame_start_o(frame_start_o), .underflow_o(underflow_o)
    );

    typedef struct {
        bit         hs;
        bit         vs;
        bit         bl;
        bit         fs;
        logic [7:0] rgb;
        bit         drop;
    } exp_t;

    typedef struct {
        bit         req;
        logic [8:0] x;
        logic [8:0] y;
        bit         drop;
    } src_t;

    exp_t exp_q[$];
    bit   drop_q[$];
    int   clr_when[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit running = 1'b0;
    int mult = 0;

    bit m_uf, m_prev_clr, seen_fs;
    int cnt_hs, cnt_vs, cnt_req, cnt_act, frames_checked = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] px_val(int x, int y);
        return 8'((x + y * mult) & 255);
    endfunction

    function automatic exp_t model(int h, int v, bit drop);
        exp_t e;
        bit   act;
        act    = (h < HA) && (v < VA);
        e.hs   = !((h >= HSS) && (h < HSS + HSL));
        e.vs   = !((v >= VSS) && (v < VSS + VSL));
        e.bl   = !act;
        e.fs   = (h == 0) && (v == 0);
        e.drop = act && drop;
        if (!act || e.drop) e.rgb = 8'd0;
        else if (BARS)      e.rgb = 8'(h);
        else                e.rgb = px_val(h, v);
        return e;
    endfunction

    task automatic chk_reset(string tag);
        chk({tag, "_hsync"}, hsync_o, 1);
        chk({tag, "_vsync"}, vsync_o, 1);
        chk({tag, "_blank"}, blank_o, 1);
        chk({tag, "_rgb"}, rgb_o, 0);
        chk({tag, "_pix_req"}, pix_req, 0);
        chk({tag, "_frame_start"}, frame_start_o, 0);
        chk({tag, "_underflow"}, underflow_o, 0);
    endtask

    // Outputs stay idle for the LAT+1 clocks the pipe takes to fill after release.
    task automatic start_run();
        exp_t idle;
        idle = '{hs: 1, vs: 1, bl: 1, fs: 0, rgb: 8'd0, drop: 0};
        for (int i = 0; i < LAT + 1; i++) exp_q.push_back(idle);
        m_uf = 0; m_prev_clr = 0; seen_fs = 0;
        cnt_hs = 0; cnt_vs = 0; cnt_req = 0; cnt_act = 0;
        running = 1'b1;
    endtask

    // Pixel source: answers each request LAT clocks later, and chatters pix_valid when idle.
    initial begin
        src_t spipe [LAT];
        src_t cap;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        for (int i = 0; i < LAT; i++) spipe[i] = '{req: 0, x: 0, y: 0, drop: 0};
        forever begin
            @(negedge clk6m);
            cap = '{req: pix_req, x: pix_x, y: pix_y, drop: 0};
            if (pix_req === 1'b1 && drop_q.size() > 0) cap.drop = drop_q.pop_front();
            @(posedge clk6m);
            for (int i = LAT - 1; i > 0; i--) spipe[i] = spipe[i-1];
            spipe[0] = cap;
            #1;
            if (spipe[LAT-1].req) begin
                pix_valid = !spipe[LAT-1].drop;
                pix_data  = spipe[LAT-1].drop ? 8'($urandom) : px_val(spipe[LAT-1].x, spipe[LAT-1].y);
            end else begin
                pix_valid = ($urandom_range(0, 3) == 0);
                pix_data  = 8'($urandom);
            end
        end
    end

    // Monitor: one expected bundle per clock while running.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk6m);
            if (running) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL scoreboard_empty @%0t: got 0 entries, expected at least 1", $time);
                end else begin
                    e = exp_q.pop_front();
                    m_uf = e.drop | (m_uf & !m_prev_clr);
                    chk("hsync_o", hsync_o, e.hs);
                    chk("vsync_o", vsync_o, e.vs);
                    chk("blank_o", blank_o, e.bl);
                    chk("frame_start_o", frame_start_o, e.fs);
                    chk("rgb_o", rgb_o, e.rgb);
                    chk("underflow_o", underflow_o, m_uf);
                end
                m_prev_clr = clr_underflow;
                if (frame_start_o === 1'b1) begin
                    if (seen_fs) begin
                        chk("frame_hsync_low", cnt_hs, HSL * VT);
                        chk("frame_vsync_low", cnt_vs, VSL * HT);
                        chk("frame_pix_req", cnt_req, BARS ? 0 : HA * VA);
                        chk("frame_active", cnt_act, HA * VA);
                        frames_checked++;
                    end
                    seen_fs = 1;
                    cnt_hs = 0; cnt_vs = 0; cnt_req = 0; cnt_act = 0;
                end
                cnt_hs  += (hsync_o === 1'b0) ? 1 : 0;
                cnt_vs  += (vsync_o === 1'b0) ? 1 : 0;
                cnt_req += (pix_req === 1'b1) ? 1 : 0;
                cnt_act += (blank_o === 1'b0) ? 1 : 0;
            end
        end
    end

    // Reference raster: walks (h,v) one clock at a time, pushing expectations and drop decisions.
    task automatic run(int phase, int limit);
        int  h = 0, v = 0, frm = 0;
        bit  drop, act, clr;
        for (int c = 0; c < limit; c++) begin
            if (phase == 1 && frm == 1 && h == 200 && v == 10) break;
            act  = (h < HA) && (v < VA);
            drop = 0;
            if (!BARS && act) begin
                if (phase == 1 && frm == 0 && ((h == 10 && v == 5) || (h == 20 && v == 7))) drop = 1;
                if (phase == 2 && $urandom_range(0, 31) == 0) drop = 1;
                drop_q.push_back(drop);
            end
            if (phase == 1 && frm == 0) begin
                if (h == 10 && v == 5) clr_when.push_back(c + LAT + 2 + 100);
                if (h == 20 && v == 7) clr_when.push_back(c + LAT + 1);
                if (h == 5 && v == 9)  clr_when.push_back(c + LAT + 1);
            end
            exp_q.push_back(model(h, v, drop));
            clr = 0;
            if (clr_when.size() > 0 && clr_when[0] == c) begin
                clr = 1;
                void'(clr_when.pop_front());
            end
            if (phase == 2 && $urandom_range(0, 499) == 0) clr = 1;
            clr_underflow = clr;
            @(posedge clk6m);
            #1;
            h++;
            if (h == HT) begin
                h = 0;
                v++;
                if (v == VT) begin
                    v = 0;
                    frm++;
                end
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        clr_underflow = 1'b0;
        repeat (3) @(posedge clk6m);
        @(negedge clk6m); #1;
        chk_reset("reset");

        // Phase 1: pure x ramp, directed drops and clears, then a mid-line reset.
        mult = 0;
        reset_n = 1'b1;
        start_run();
        run(1, 2 * FRAME);

        @(negedge clk6m); #2;
        running = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset("async_reset");
        exp_q.delete();
        drop_q.delete();
        clr_when.delete();
        clr_underflow = 1'b0;
        @(negedge clk6m); #1;

        // Phase 2: scrambled pixel values, random drops and clears.
        mult = $urandom_range(1, 255);
        reset_n = 1'b1;
        start_run();
        run(2, 3 * FRAME + 10);

        @(negedge clk6m); #1;
        running = 1'b0;
        chk("frames_checked", frames_checked, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
